// File: rtl/vector_mem_unit.sv
// Strided vector load/store sequencer.
// Issues one memory beat per lane and assembles loaded lanes into load_data.
module vector_mem_unit #(
   parameter int LANES = 8,
   parameter int WORD  = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  is_load,
   input  logic [31:0]           base_addr,
   input  logic [31:0]           stride,
   input  logic [LANES*WORD-1:0] store_data,
   input  logic [WORD-1:0]       mem_rdata,
   output logic [31:0]           mem_addr,
   output logic [WORD-1:0]       mem_wdata,
   output logic                  mem_we,
   output logic                  mem_re,
   output logic [LANES*WORD-1:0] load_data,
   output logic                  busy,
   output logic                  done
);

   localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int VW = LANES * WORD;
   localparam logic [CW-1:0] LAST = CW'(LANES - 1);

   typedef enum logic [2:0] {
      IDLE,
      STORE,
      LOAD,
      LOAD_LAST,
      DONE
   } state_t;

   state_t          st, nxt;
   logic [CW-1:0]   cnt;
   logic [31:0]     addr_q;
   logic [31:0]     stride_q;
   logic [VW-1:0]   sdata_q;
   logic [VW-1:0]   ld_q;
   logic            last;
   logic            wr_en;
   logic [CW-1:0]   wr_idx;

   assign last = (cnt == LAST);

   // Read data trails the strobe by one cycle, so lane cnt-1 lands now.
   assign wr_en  = ((st == LOAD) && (cnt != '0)) || (st == LOAD_LAST);
   assign wr_idx = (st == LOAD_LAST) ? LAST : cnt - 1'b1;

   always_comb begin
      nxt = st;
      unique case (st)
         IDLE:      if (start) nxt = is_load ? LOAD : STORE;
         STORE:     if (last) nxt = DONE;
         LOAD:      if (last) nxt = LOAD_LAST;
         LOAD_LAST: nxt = DONE;
         DONE:      nxt = IDLE;
         default:   nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st       <= IDLE;
         cnt      <= '0;
         addr_q   <= '0;
         stride_q <= '0;
         sdata_q  <= '0;
         ld_q     <= '0;
      end else begin
         st <= nxt;
         if ((st == IDLE) && start) begin
            cnt      <= '0;
            addr_q   <= base_addr;
            stride_q <= stride;
            sdata_q  <= store_data;
         end else if ((st == STORE) || (st == LOAD)) begin
            cnt    <= cnt + 1'b1;
            addr_q <= addr_q + stride_q;
            if (st == STORE) sdata_q <= sdata_q >> WORD;
         end
         if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
               if (wr_idx == CW'(i)) ld_q[i*WORD +: WORD] <= mem_rdata;
            end
         end
      end
   end

   assign mem_we    = (st == STORE);
   assign mem_re    = (st == LOAD);
   assign mem_addr  = (mem_we || mem_re) ? addr_q : '0;
   assign mem_wdata = mem_we ? sdata_q[WORD-1:0] : '0;
   assign load_data = ld_q;
   assign busy      = (st != IDLE);
   assign done      = (st == DONE);

endmodule

// File: tb/tb_vector_mem_unit.sv
// Scoreboard bench for vector_mem_unit.
// Memory beats and done pulses are checked against a lane-level reference.
module tb_vector_mem_unit;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic         is_load;
   logic [31:0]  base_addr;
   logic [31:0]  stride;
   logic [255:0] store_data;
   logic [31:0]  mem_rdata;
   logic [31:0]  mem_addr;
   logic [31:0]  mem_wdata;
   logic         mem_we;
   logic         mem_re;
   logic [255:0] load_data;
   logic         busy;
   logic         done;

   vector_mem_unit #(.LANES(8), .WORD(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .is_load    (is_load),
      .base_addr  (base_addr),
      .stride     (stride),
      .store_data (store_data),
      .mem_rdata  (mem_rdata),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we),
      .mem_re     (mem_re),
      .load_data  (load_data),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  kind;
      logic [31:0] addr;
      logic [31:0] data;
      int          cyc;
   } ev_t;

   ev_t q[$];
   ev_t me;
   int errors = 0;
   int checks = 0;
   int cyc = 0;

   logic [31:0]  mem[logic [31:0]];
   logic [31:0]  ref_mem[logic [31:0]];
   logic [255:0] ref_ld = '0;

   function automatic logic [31:0] mem_rd(logic [31:0] a);
      return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A5A5A);
   endfunction

   function automatic logic [31:0] ref_rd(logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : (a ^ 32'h5A5A5A5A);
   endfunction

   task automatic chk(string name, logic [255:0] got, logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Reference: lane i touches base + i*stride; done follows the beats.
   function automatic void push_op(int s, bit ld, logic [31:0] b,
                                   logic [31:0] st, logic [255:0] d);
      ev_t e;
      logic [31:0] a;
      for (int i = 0; i < 8; i++) begin
         a = b + st * 32'(i);
         e.kind = ld ? 3'b010 : 3'b001;
         e.addr = a;
         e.data = ld ? 32'h0 : d[i*32 +: 32];
         e.cyc  = s + 1 + i;
         q.push_back(e);
         if (ld) ref_ld[i*32 +: 32] = ref_rd(a);
         else ref_mem[a] = d[i*32 +: 32];
      end
      e.kind = 3'b100;
      e.addr = '0;
      e.data = '0;
      e.cyc  = s + (ld ? 10 : 9);
      q.push_back(e);
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_we) mem[mem_addr] = mem_wdata;
      mem_rdata <= mem_re ? mem_rd(mem_addr) : $urandom;
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_we && mem_re) chk("strobe overlap", 1, 0);
         if (mem_we || mem_re || done) begin
            if (q.size() == 0) begin
               chk("unexpected event", {done, mem_re, mem_we, mem_addr}, 0);
            end else begin
               me = q.pop_front();
               chk("mem event",
                   {done, mem_re, mem_we, mem_addr, mem_wdata, cyc},
                   {me.kind, me.addr, me.data, me.cyc});
            end
         end else if (mem_addr != 0 || mem_wdata != 0) begin
            chk("idle bus", {mem_addr, mem_wdata}, 0);
         end
      end
   end

   task automatic run_op(bit ld, logic [31:0] b, logic [31:0] st,
                         logic [255:0] d);
      int s;
      @(negedge clk);
      start      = 1'b1;
      is_load    = ld;
      base_addr  = b;
      stride     = st;
      store_data = d;
      @(posedge clk);
      #1;
      s = cyc - 1;
      start = 1'b0;
      push_op(s, ld, b, st, d);
      for (int k = 1; k <= (ld ? 10 : 9); k++) begin
         @(negedge clk);
         chk("busy during op", busy, 1);
      end
      @(negedge clk);
      chk("busy after op", {busy, done}, 0);
      chk("load_data", load_data, ref_ld);
   endtask

   function automatic logic [255:0] rnd_vec();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   logic [255:0] d;
   logic [31:0]  b;
   logic [31:0]  st;
   int           s;

   initial begin
      rst_n      = 1'b0;
      start      = 1'b0;
      is_load    = 1'b0;
      base_addr  = '0;
      stride     = '0;
      store_data = '0;
      #1;
      chk("reset outputs",
          {mem_addr, mem_wdata, mem_we, mem_re, busy, done}, 0);
      chk("reset load_data", load_data, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) d[i*32 +: 32] = 32'h11111111 * (i + 1);
      run_op(1'b0, 32'h100, 32'd4, d);

      for (int i = 0; i < 8; i++) begin
         mem[32'h200 + 8 * i]     = 32'hA0000000 + i;
         ref_mem[32'h200 + 8 * i] = 32'hA0000000 + i;
      end
      run_op(1'b1, 32'h200, 32'd8, rnd_vec());
      for (int i = 0; i < 8; i++) d[i*32 +: 32] = 32'hA0000000 + i;
      chk("load literal", load_data, d);

      run_op(1'b0, 32'hFFFFFFF8, 32'd4, rnd_vec());
      run_op(1'b1, 32'h200, 32'd0, '0);
      chk("stride0 load", load_data, {8{32'hA0000000}});

      // Start held high: DONE ignores it, the next IDLE cycle accepts it.
      @(negedge clk);
      d          = rnd_vec();
      start      = 1'b1;
      is_load    = 1'b0;
      base_addr  = 32'h400;
      stride     = 32'd4;
      store_data = d;
      @(posedge clk);
      #1;
      s = cyc - 1;
      push_op(s, 1'b0, 32'h400, 32'd4, d);
      d          = rnd_vec();
      base_addr  = 32'h800;
      stride     = 32'd12;
      store_data = d;
      push_op(s + 10, 1'b0, 32'h800, 32'd12, d);
      repeat (10) @(posedge clk);
      #1;
      start = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         chk("busy held start", busy, 1);
      end
      @(negedge clk);
      chk("idle after held", busy, 0);
      run_op(1'b1, 32'h800, 32'd12, '0);

      for (int n = 0; n < 12; n++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         case ($urandom_range(0, 2))
            0: b = 32'h1000;
            1: b = 32'h1040;
            default: b = 32'hFFFFFFF0;
         endcase
         case ($urandom_range(0, 3))
            0: st = 32'd0;
            1: st = 32'd4;
            2: st = 32'd8;
            default: st = $urandom;
         endcase
         run_op(1'($urandom_range(0, 1)), b, st, rnd_vec());
      end

      // Abort a store during its third beat.
      @(negedge clk);
      d          = rnd_vec();
      start      = 1'b1;
      is_load    = 1'b0;
      base_addr  = 32'h3000;
      stride     = 32'd4;
      store_data = d;
      @(posedge clk);
      #1;
      s = cyc - 1;
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         me.kind = 3'b001;
         me.addr = 32'h3000 + 4 * i;
         me.data = d[i*32 +: 32];
         me.cyc  = s + 1 + i;
         q.push_back(me);
         if (i < 2) ref_mem[32'h3000 + 4 * i] = d[i*32 +: 32];
      end
      repeat (3) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort outputs",
          {mem_addr, mem_wdata, mem_we, mem_re, busy, done}, 0);
      chk("abort load_data", load_data, 0);
      ref_ld = '0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("idle after abort", busy, 0);
      end
      run_op(1'b1, 32'h3000, 32'd4, '0);
      run_op(1'b0, 32'h3000, 32'd4, rnd_vec());
      run_op(1'b1, 32'h3000, 32'd4, '0);

      repeat (3) @(negedge clk);
      chk("scoreboard drained", 256'(q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vector_mem_unit.md
VECTOR_MEM_UNIT -- requirements
Module: vector_mem_unit

Interface
REQ-001 SHALL have parameter LANES, default 8: number of 32-bit lanes per vector.
REQ-002 SHALL have parameter WORD, default 32: lane width in bits; vector width is LANES*WORD (256).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port start  input  1  request a vector access; sampled only in IDLE.
REQ-006 SHALL have port is_load  input  1  1 = vector load, 0 = vector store; captured with start.
REQ-007 SHALL have port base_addr  input  32  byte address of lane 0; captured with start.
REQ-008 SHALL have port stride  input  32  byte increment between consecutive lanes; captured with start.
REQ-009 SHALL have port store_data  input  256  vector to store, lane i = bits [32i+31:32i]; captured with start.
REQ-010 SHALL have port mem_rdata  input  32  memory read data, valid the cycle after mem_re.
REQ-011 SHALL have port mem_addr  output  32  memory byte address.
REQ-012 SHALL have port mem_wdata  output  32  memory write data.
REQ-013 SHALL have port mem_we  output  1  memory write strobe.
REQ-014 SHALL have port mem_re  output  1  memory read strobe.
REQ-015 SHALL have port load_data  output  256  assembled load vector, lane i = bits [32i+31:32i].
REQ-016 SHALL have port busy  output  1  pipeline stall; high whenever state is not IDLE.
REQ-017 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-018 SHALL implement states IDLE, STORE, LOAD, LOAD_LAST, DONE; all outputs registered or decoded from registered state only.
REQ-019 In IDLE with start=1, SHALL capture is_load, base_addr, stride, store_data, clear lane counter, and go to LOAD if is_load else STORE.
REQ-020 start SHALL be ignored in every state other than IDLE, including DONE; captured operands SHALL not change during an operation.
REQ-021 Lane i address SHALL be base_addr + i*stride, computed modulo 2^32 (wrap-around, no fault).
REQ-022 STORE: for i = 0..LANES-1 in consecutive cycles, mem_we=1, mem_addr = lane i address, mem_wdata = captured lane i; after lane LANES-1, go to DONE.
REQ-023 LOAD: for i = 0..LANES-1 in consecutive cycles, mem_re=1, mem_addr = lane i address; after lane LANES-1, go to LOAD_LAST.
REQ-024 mem_rdata of the cycle following the read of lane i SHALL be written into load_data lane i at that cycle's closing edge; lanes 0..6 are captured in LOAD, lane 7 in LOAD_LAST (mem_re=0).
REQ-025 LOAD_LAST SHALL go to DONE unconditionally; DONE SHALL go to IDLE unconditionally.
REQ-026 Latency from start edge: store = LANES beats, done in cycle LANES+1 (9); load = LANES read beats, done in cycle LANES+2 (10).
REQ-027 done SHALL be high only in DONE; busy SHALL be high in STORE, LOAD, LOAD_LAST, DONE.
REQ-028 mem_we and mem_re SHALL never be high simultaneously; both 0 in IDLE and DONE; mem_addr and mem_wdata 0 when both strobes are low.
REQ-029 load_data SHALL hold its value outside loads; a store SHALL not modify it; a new load overwrites lanes progressively.
REQ-030 stride = 0 SHALL be legal: all lanes access base_addr.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, counter 0, captured operands 0, load_data 0, and mem_addr, mem_wdata, mem_we, mem_re, busy, done all 0.
REQ-032 Reset mid-operation SHALL abort with no further memory strobes; first operation after rst_n release requires a fresh start.

Verification
REQ-033 Store: base 0x100, stride 4, lane i = 0x11111111*(i+1) -> mem_we cycles 1-8 at 0x100..0x11C with data 0x11111111..0x88888888, done cycle 9, busy cycles 1-9.
REQ-034 Load: memory word at 0x200+8i = 0xA0000000+i, base 0x200, stride 8 -> mem_re cycles 1-8, done cycle 10, load_data lane i = 0xA0000000+i.
REQ-035 Wrap: store base 0xFFFFFFF8, stride 4 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4, ..., 0x14.
REQ-036 Start held high through a store -> exactly 8 writes, start in DONE ignored, new operation accepted in first cycle after DONE.
REQ-037 rst_n low during store beat 3 -> all outputs 0 immediately, no strobes after release until next start; load_data 0.
REQ-038 Store after load -> load_data unchanged; stride 0 load -> all lanes equal word at base.
